shift_pipe: RTL

- Parametrised, pipelined successor of the fixed shift-by-2 block.
- Shifts a signed operand by a runtime amount in one of four modes: logical left, saturating arithmetic left, logical right, arithmetic right.
- Reports signed overflow on left shifts.
- Sits on valid/ready streams between datapath blocks and accepts one operation per cycle, with full backpressure.

---
 rtl/shift_pipe_pkg.sv | 27 ++
 rtl/shift_pipe_stage.sv | 101 ++++++++++
 rtl/shift_pipe.sv | 86 ++++++++
 3 files changed

// File: rtl/shift_pipe_pkg.sv
// shift_pkg: shared types and helpers for the shift_pipe datapath.
//   op_e                 : shift mode encoding (matches the op port)
//   stage_ctl_t          : fixed-width per-stage control payload
//   shamt_bits_per_stage : shift-amount bits consumed by each pipeline stage
// The value and remaining-shift-amount fields of the stage payload depend
// on module parameters, so they travel beside stage_ctl_t as plain vectors.
package shift_pkg;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SLA = 2'b01,
      OP_SRL = 2'b10,
      OP_SRA = 2'b11
   } op_e;

   typedef struct packed {
      op_e  op;   // shift mode carried down the pipe
      logic ovf;  // sticky signed-overflow flag
      logic neg;  // sign of the original operand, picks the saturation rail
   } stage_ctl_t;

   // Shift-amount bits handled per stage, LSBs first.
   function automatic int shamt_bits_per_stage(input int shamt_width, input int stages);
      return (shamt_width + stages - 1) / stages;
   endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// shift_stage: one pipeline stage of shift_pipe.
// Applies shift-amount bits [LO +: NBITS] to the partial value, accumulates
// sticky overflow for left shifts, and registers the result behind a
// valid/ready slice. The LAST stage also applies SLA saturation.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   vld_i / adv_o         upstream valid / this stage can load (ready)
//   val_i, shamt_i, ctl_i payload from the previous stage
//   vld_o / nxt_adv_i     registered valid / downstream stage advances
//   val_o, shamt_o, ctl_o registered payload
module shift_stage
   import shift_pkg::*;
#(
   parameter int RES_WIDTH   = 32,
   parameter int SHAMT_WIDTH = 6,
   parameter int LO          = 0,
   parameter int NBITS       = 1,
   parameter bit LAST        = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   vld_i,
   output logic                   adv_o,
   input  logic [RES_WIDTH-1:0]   val_i,
   input  logic [SHAMT_WIDTH-1:0] shamt_i,
   input  stage_ctl_t             ctl_i,
   output logic                   vld_o,
   input  logic                   nxt_adv_i,
   output logic [RES_WIDTH-1:0]   val_o,
   output logic [SHAMT_WIDTH-1:0] shamt_o,
   output stage_ctl_t             ctl_o
);

   logic                   vld_q;
   logic [RES_WIDTH-1:0]   val_q, val_d;
   logic [SHAMT_WIDTH-1:0] shamt_q, shamt_d;
   stage_ctl_t             ctl_q, ctl_d;
   logic                   left;
   logic signed [RES_WIDTH-1:0] top;

   always_comb begin
      val_d   = val_i;
      shamt_d = shamt_i;
      ctl_d   = ctl_i;
      top     = '0;
      left    = (ctl_i.op == OP_SLL) || (ctl_i.op == OP_SLA);
      for (int j = 0; j < SHAMT_WIDTH; j++) begin
         if (j >= LO && j < LO + NBITS && shamt_i[j]) begin
            shamt_d[j] = 1'b0;
            if ((longint'(1) << j) >= longint'(RES_WIDTH)) begin
               // Whole word shifted out: any nonzero value overflows left.
               if (left) begin
                  ctl_d.ovf = ctl_d.ovf | (|val_d);
               end
               val_d = (ctl_i.op == OP_SRA) ? {RES_WIDTH{val_d[RES_WIDTH-1]}} : '0;
            end else if (left) begin
               // The value stays representable only if the bits shifted out
               // and the new sign bit all equal the current sign.
               top = $signed(val_d) >>> (RES_WIDTH - 1 - (1 << j));
               if (!((&top) || !(|top))) begin
                  ctl_d.ovf = 1'b1;
               end
               val_d = val_d << (1 << j);
            end else if (ctl_i.op == OP_SRA) begin
               val_d = $signed(val_d) >>> (1 << j);
            end else begin
               val_d = val_d >> (1 << j);
            end
         end
      end
      if (LAST && ctl_i.op == OP_SLA && ctl_d.ovf) begin
         val_d = ctl_i.neg ? {1'b1, {(RES_WIDTH-1){1'b0}}} : {1'b0, {(RES_WIDTH-1){1'b1}}};
      end
   end

   assign adv_o = !vld_q || nxt_adv_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q   <= 1'b0;
         val_q   <= '0;
         shamt_q <= '0;
         ctl_q   <= '0;
      end else if (adv_o) begin
         vld_q <= vld_i;
         // Payload only loads with a real operation, so an idle pipe
         // leaves the last result on the outputs.
         if (vld_i) begin
            val_q   <= val_d;
            shamt_q <= shamt_d;
            ctl_q   <= ctl_d;
         end
      end
   end

   assign vld_o   = vld_q;
   assign val_o   = val_q;
   assign shamt_o = shamt_q;
   assign ctl_o   = ctl_q;

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined signed shifter with valid/ready handshakes.
// Modes SLL, SLA (saturating), SRL, SRA by a runtime amount, signed
// overflow reporting on left shifts, latency STAGES, one op per cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   arg_vld / arg_rdy   input handshake
//   a, shamt, op        operand, shift amount, mode
//   res_vld / res_rdy   output handshake
//   res, overflow       result and overflow flag (qualified by res_vld)
module shift_pipe
   import shift_pkg::*;
#(
   parameter int ARG_WIDTH   = 32,
   parameter int RES_WIDTH   = ARG_WIDTH,
   parameter int SHAMT_WIDTH = $clog2(RES_WIDTH) + 1,
   parameter int STAGES      = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   arg_vld,
   output logic                   arg_rdy,
   input  logic [ARG_WIDTH-1:0]   a,
   input  logic [SHAMT_WIDTH-1:0] shamt,
   input  logic [1:0]             op,
   output logic                   res_vld,
   input  logic                   res_rdy,
   output logic [RES_WIDTH-1:0]   res,
   output logic                   overflow
);

   localparam int BPS = shamt_bits_per_stage(SHAMT_WIDTH, STAGES);

   if (RES_WIDTH < ARG_WIDTH) begin : g_bad_width
      $error("shift_pipe: RES_WIDTH must be >= ARG_WIDTH");
   end
   if (STAGES < 1 || STAGES > SHAMT_WIDTH) begin : g_bad_stages
      $error("shift_pipe: STAGES must be in 1..SHAMT_WIDTH");
   end

   // Element k feeds stage k; element STAGES is the pipe output.
   logic                   vld_w   [0:STAGES];
   logic                   adv_w   [0:STAGES];
   logic [RES_WIDTH-1:0]   val_w   [0:STAGES];
   logic [SHAMT_WIDTH-1:0] shamt_w [0:STAGES];
   stage_ctl_t             ctl_w   [0:STAGES];
   logic                   unused_tail;

   // SRL works on the unsigned bit pattern; the other modes on the signed value.
   assign val_w[0]   = (op_e'(op) == OP_SRL) ? RES_WIDTH'(a) : RES_WIDTH'($signed(a));
   assign vld_w[0]   = arg_vld;
   assign shamt_w[0] = shamt;
   assign ctl_w[0]   = '{op: op_e'(op), ovf: 1'b0, neg: a[ARG_WIDTH-1]};
   assign adv_w[STAGES] = res_rdy;
   assign arg_rdy       = adv_w[0];

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      shift_stage #(
         .RES_WIDTH   (RES_WIDTH),
         .SHAMT_WIDTH (SHAMT_WIDTH),
         .LO          (gi * BPS),
         .NBITS       (BPS),
         .LAST        (gi == STAGES - 1)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .vld_i     (vld_w[gi]),
         .adv_o     (adv_w[gi]),
         .val_i     (val_w[gi]),
         .shamt_i   (shamt_w[gi]),
         .ctl_i     (ctl_w[gi]),
         .vld_o     (vld_w[gi+1]),
         .nxt_adv_i (adv_w[gi+1]),
         .val_o     (val_w[gi+1]),
         .shamt_o   (shamt_w[gi+1]),
         .ctl_o     (ctl_w[gi+1])
      );
   end

   assign res_vld  = vld_w[STAGES];
   assign res      = val_w[STAGES];
   assign overflow = ctl_w[STAGES].ovf;

   // Fields that have no consumer past the final stage.
   assign unused_tail = ^{shamt_w[STAGES], ctl_w[STAGES].op, ctl_w[STAGES].neg};

endmodule
